// File: rtl/lms_train_gen.sv
//==============================================================================
// Module      : lms_train_gen
// Description : Training-sequence source for a 2-tap LMS adaptive FIR.
//               Emits a PRBS7 antipodal sample (x_out) and the output of a
//               programmable L-tap reference channel (d_out) for
//               system-identification bursts.
//               Optional macro LMS_TRAIN_NOISE_EN adds +/-1 LSB PRBS15 noise
//               to the channel output before saturation.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lms_train_gen #(
  parameter int W1  = 8,   // sample / coefficient width (coefs Q1.7)
  parameter int W2  = 16,  // product width
  parameter int L   = 2,   // channel taps (1..4)
  parameter int AMP = 64   // PRBS amplitude
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coef_we,
  input  logic [1:0]    coef_addr,
  input  logic [W1-1:0] coef_data,
  input  logic          start,
  input  logic [15:0]   burst_len,
  output logic [W1-1:0] x_out,
  output logic [W1-1:0] d_out,
  output logic          valid,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Delay line holds x[n-1] .. x[n-L+1]; keep at least one entry so L=1 builds.
  localparam int                   DLY       = (L > 1) ? L - 1 : 1;
  localparam int                   SW        = W2 + 2;
  localparam logic [6:0]           PRBS_SEED = 7'h7F;
  localparam logic signed [W1-1:0] X_POS     = W1'(AMP);
  localparam logic signed [W1-1:0] X_NEG     = W1'(-AMP);
  localparam logic signed [SW-1:0] SAT_MAX   = SW'((2 ** (W1 - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN   = SW'(-(2 ** (W1 - 1)));

  state_t                state_q, state_d;
  logic [6:0]            lfsr_q, lfsr_d;
  logic signed [W1-1:0]  coef_q [L];
  logic signed [W1-1:0]  coef_d [L];
  logic signed [W1-1:0]  dly_q [DLY];
  logic signed [W1-1:0]  dly_d [DLY];
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           len_q, len_d;
  logic [W1-1:0]         x_out_q, x_out_d;
  logic [W1-1:0]         d_out_q, d_out_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

`ifdef LMS_TRAIN_NOISE_EN
  localparam logic [14:0] NOISE_SEED = 15'h0001;
  logic [14:0]           noise_q, noise_d, noise_src;
`endif

  // Datapath intermediates
  logic                  load;
  logic                  emit;
  logic [6:0]            lfsr_src;
  logic signed [W1-1:0]  x_cur;
  logic signed [W1-1:0]  tap [L];
  logic signed [W2-1:0]  prod;
  logic signed [SW-1:0]  acc;
  logic signed [SW-1:0]  shifted;
  logic signed [SW-1:0]  noisy;
  logic [W1-1:0]         d_sat;

  // A burst (re)starts from a fresh LFSR and cleared delay line; a new sample
  // is produced on the start edge itself and on every RUN cycle until the count.
  assign load = (state_q == S_IDLE) && start;
  assign emit = (load && (burst_len != 16'd0)) ||
                ((state_q == S_RUN) && (cnt_q != len_q));

  // Coefficient writes only land in IDLE; forwarded so a same-cycle start sees them.
  always_comb begin
    for (int i = 0; i < L; i++) coef_d[i] = coef_q[i];
    if ((state_q == S_IDLE) && coef_we) begin
      for (int i = 0; i < L; i++) begin
        if (coef_addr == 2'(i)) coef_d[i] = coef_data;
      end
    end
  end

  // Channel FIR on the current PRBS sample plus delay line, shift, optional noise, saturate.
  always_comb begin
    lfsr_src = load ? PRBS_SEED : lfsr_q;
    x_cur    = lfsr_src[6] ? X_NEG : X_POS;
    tap[0]   = x_cur;
    for (int i = 1; i < L; i++) tap[i] = load ? '0 : dly_q[i-1];
    prod = '0;
    acc  = '0;
    for (int i = 0; i < L; i++) begin
      prod = W2'(coef_d[i]) * W2'(tap[i]);
      acc  = acc + SW'(prod);
    end
    shifted = acc >>> (W1 - 1);
`ifdef LMS_TRAIN_NOISE_EN
    noise_src = load ? NOISE_SEED : noise_q;
    noisy     = noise_src[14] ? (shifted - SW'(1)) : (shifted + SW'(1));
`else
    noisy     = shifted;
`endif
    if (noisy > SAT_MAX)      d_sat = {1'b0, {(W1-1){1'b1}}};
    else if (noisy < SAT_MIN) d_sat = {1'b1, {(W1-1){1'b0}}};
    else                      d_sat = noisy[W1-1:0];
  end

  // Burst sequencing and next values for sample, LFSR and delay-line registers.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    for (int i = 0; i < DLY; i++) dly_d[i] = dly_q[i];
    cnt_d   = cnt_q;
    len_d   = len_q;
    x_out_d = x_out_q;
    d_out_d = d_out_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy_q;
`ifdef LMS_TRAIN_NOISE_EN
    noise_d = noise_q;
`endif

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          len_d  = burst_len;
          lfsr_d = PRBS_SEED;
          busy_d = 1'b1;
          if (burst_len == 16'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (cnt_q == len_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (emit) begin
      lfsr_d   = {lfsr_src[5:0], lfsr_src[6] ^ lfsr_src[5]};
      dly_d[0] = x_cur;
      for (int i = 1; i < DLY; i++) dly_d[i] = tap[i];
      cnt_d    = (load ? 16'd0 : cnt_q) + 16'd1;
      x_out_d  = x_cur;
      d_out_d  = d_sat;
      valid_d  = 1'b1;
`ifdef LMS_TRAIN_NOISE_EN
      noise_d  = {noise_src[13:0], noise_src[14] ^ noise_src[13]};
`endif
    end
  end

  // State, coefficient and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= PRBS_SEED;
      for (int i = 0; i < DLY; i++) dly_q[i] <= '0;
      for (int i = 0; i < L; i++)   coef_q[i] <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      x_out_q <= '0;
      d_out_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LMS_TRAIN_NOISE_EN
      noise_q <= NOISE_SEED;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      for (int i = 0; i < DLY; i++) dly_q[i] <= dly_d[i];
      for (int i = 0; i < L; i++)   coef_q[i] <= coef_d[i];
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      x_out_q <= x_out_d;
      d_out_q <= d_out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef LMS_TRAIN_NOISE_EN
      noise_q <= noise_d;
`endif
    end
  end

  assign x_out = x_out_q;
  assign d_out = d_out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_lms_train_gen.sv
//==============================================================================
// Module      : tb_lms_train_gen
// Description : Directed self-checking bench for lms_train_gen.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_lms_train_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_addr = 2'd0;
  logic [7:0]  coef_data = 8'd0;
  logic        start = 1'b0;
  logic [15:0] burst_len = 16'd0;
  logic [7:0]  x_out;
  logic [7:0]  d_out;
  logic        valid;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  lms_train_gen #(.W1(8), .W2(16), .L(2), .AMP(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .start     (start),
    .burst_len (burst_len),
    .x_out     (x_out),
    .d_out     (d_out),
    .valid     (valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference PRBS7: x^7+x^6+1, output bit is s[6], -64 when set.
  function automatic logic [6:0] prbs_next(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  function automatic logic [7:0] prbs_x(input logic [6:0] s);
    return s[6] ? 8'hC0 : 8'h40;
  endfunction

  // Channel h0=0.5, h1=0: d = x/2.
  function automatic logic [7:0] half_d(input logic [6:0] s);
    return s[6] ? 8'hE0 : 8'h20;
  endfunction

  task automatic wr_coef(input logic [1:0] a, input logic [7:0] v);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = v;
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic start_burst(input logic [15:0] len);
    start     = 1'b1;
    burst_len = len;
    @(negedge clk);
    start     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] ms;
    logic [7:0] tr1 [254];
    logic [7:0] x3 [10];
    logic [7:0] d3 [10];
    int errs;
    int seen;

    x3 = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h40, 8'h40, 8'h40};
    d3 = '{8'h40, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h80, 8'h80};

    // Reset
    repeat (2) @(negedge clk);
    check("rst_x", x_out, 0);
    check("rst_d", d_out, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic 4-sample burst, h0=0.5
    wr_coef(2'd0, 8'h40);
    wr_coef(2'd1, 8'h00);
    start_burst(16'd4);
    for (int k = 0; k < 4; k++) begin
      check("b4_valid", valid, 1);
      check("b4_x", x_out, 8'hC0);
      check("b4_d", d_out, 8'hE0);
      @(negedge clk);
    end
    check("b4_done", done, 1);
    check("b4_done_valid", valid, 0);
    check("b4_done_busy", busy, 1);
    check("b4_hold_x", x_out, 8'hC0);
    @(negedge clk);
    check("b4_done_clr", done, 0);
    check("b4_idle_busy", busy, 0);

    // Saturation, h0=h1=-1.0
    wr_coef(2'd0, 8'h80);
    wr_coef(2'd1, 8'h80);
    start_burst(16'd10);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("sat_x%0d", k), x_out, x3[k]);
      check($sformatf("sat_d%0d", k), d_out, d3[k]);
      @(negedge clk);
    end
    check("sat_done", done, 1);
    @(negedge clk);

    // Long burst: trace vs model, period 127, repeatability
    wr_coef(2'd0, 8'h40);
    wr_coef(2'd1, 8'h00);
    start_burst(16'd254);
    ms = 7'h7F;
    errs = 0;
    for (int n = 0; n < 254; n++) begin
      if (valid !== 1'b1 || x_out !== prbs_x(ms) || d_out !== half_d(ms)) errs++;
      tr1[n] = x_out;
      ms = prbs_next(ms);
      @(negedge clk);
    end
    check("long_trace", errs, 0);
    check("long_done", done, 1);
    errs = 0;
    for (int n = 0; n < 127; n++) if (tr1[n] !== tr1[n+127]) errs++;
    check("long_period", errs, 0);
    @(negedge clk);
    start_burst(16'd254);
    errs = 0;
    for (int n = 0; n < 254; n++) begin
      if (valid !== 1'b1 || x_out !== tr1[n]) errs++;
      @(negedge clk);
    end
    check("long_repeat", errs, 0);
    check("long_done2", done, 1);
    @(negedge clk);

    // Out-of-range addresses ignored; writes/starts during RUN ignored
    wr_coef(2'd2, 8'h7F);
    wr_coef(2'd3, 8'h7F);
    start_burst(16'd20);
    ms = 7'h7F;
    errs = 0;
    for (int n = 0; n < 20; n++) begin
      if (valid !== 1'b1 || x_out !== prbs_x(ms) || d_out !== half_d(ms)) errs++;
      ms = prbs_next(ms);
      if (n == 3) begin
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'h7F;
        start = 1'b1; burst_len = 16'd5;
      end else if (n == 4) begin
        coef_we = 1'b0; start = 1'b0;
      end
      @(negedge clk);
    end
    check("run_ignore", errs, 0);
    check("run_done", done, 1);
    @(negedge clk);
    check("run_idle", busy, 0);

    // Zero-length burst
    start_burst(16'd0);
    check("zero_valid", valid, 0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 1);
    @(negedge clk);
    check("zero_done_clr", done, 0);
    check("zero_idle", busy, 0);

    // Coefficient write and start in the same cycle
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'h20;
    start_burst(16'd2);
    coef_we = 1'b0;
    check("fwd_x", x_out, 8'hC0);
    check("fwd_d", d_out, 8'hF0);
    repeat (3) @(negedge clk);

    // Reset mid-burst
    wr_coef(2'd0, 8'h40);
    start_burst(16'd100);
    ms = 7'h7F;
    errs = 0;
    for (int n = 0; n < 10; n++) begin
      if (x_out !== prbs_x(ms) || d_out !== half_d(ms)) errs++;
      ms = prbs_next(ms);
      @(negedge clk);
    end
    check("mid_pre", errs, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_x", x_out, 0);
    check("mid_rst_d", d_out, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_busy", busy, 0);
    seen = 0;
    for (int n = 0; n < 4; n++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      @(negedge clk);
    end
    check("mid_no_done", seen, 0);
    start_burst(16'd1);
    check("mid_coef_clr_x", x_out, 8'hC0);
    check("mid_coef_clr_d", d_out, 8'h00);
    repeat (2) @(negedge clk);
    wr_coef(2'd0, 8'h40);
    start_burst(16'd3);
    ms = 7'h7F;
    errs = 0;
    for (int n = 0; n < 3; n++) begin
      if (valid !== 1'b1 || x_out !== prbs_x(ms) || d_out !== half_d(ms)) errs++;
      ms = prbs_next(ms);
      @(negedge clk);
    end
    check("mid_replay", errs, 0);
    check("mid_replay_done", done, 1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
